instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the 128-word instruction memory. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions.
- Issues one word write per instruction into the memory's write port, using word-aligned byte addresses from 0 upward.
- Sits between the host/boot byte source and instruction memory. Holds the processor off via Busy until the image is loaded.

Parameters:
- DEPTH, 128, number of 32-bit words in the target instruction memory.
- ADDR_W, 7, word-index width; log2(DEPTH).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin a load; sampled only in IDLE.
- WordCount  input  ADDR_W+1  number of words to load; latched on accepted Start.
- ByteIn  input  8  stream byte.
- ByteValid  input  1  ByteIn valid.
- ByteReady  output  1  loader can accept a byte this cycle.
- MemWriteAddress  output  32  byte address of write; always word-aligned, bits [1:0]=0.
- MemWriteData  output  32  assembled instruction.
- MemWrite  output  1  one-cycle write strobe.
- Busy  output  1  high in LOAD and WRITE.
- Done  output  1  one-cycle pulse after the final word is written.
- Error  output  1  sticky illegal-WordCount flag; cleared on next accepted Start or on Reset.

Behaviour:
- Reset (any state, any cycle):
  - State goes to IDLE.
  - All outputs go to 0: ByteReady, MemWrite, MemWriteAddress, MemWriteData, Busy, Done, Error.
  - Byte index, word index and assembly register are cleared; any partial word is discarded.
- IDLE:
  - ByteReady=0.
  - When Start=1, Error is cleared and WordCount is latched.
  - WordCount==0 or WordCount>DEPTH: Error=1 next cycle, remain IDLE, no writes.
  - Otherwise: go to LOAD, word index=0, byte index=0.
- LOAD:
  - ByteReady=1.
  - A byte is accepted when ByteValid && ByteReady on a rising edge.
  - Byte k (k=0..3) goes to assembly bits [31-8k : 24-8k]; the first byte lands in the MSB.
  - On acceptance of byte 3, go to WRITE. ByteValid while ByteReady=0 is ignored and the byte is not consumed.
- WRITE (exactly one cycle):
  - MemWrite=1, MemWriteAddress={word_index,2'b00} zero-extended to 32 bits, MemWriteData=assembled word.
  - ByteReady=0.
  - Word index increments.
  - If the incremented index equals the latched count, go to DONE; else go to LOAD with byte index 0.
- DONE: Done=1 for one cycle, Busy=0, then return to IDLE.
- Outputs are registered. MemWriteAddress and MemWriteData hold their last value when MemWrite=0.
- Latency: 4 accepted bytes, then the write strobe appears in the cycle immediately after byte 3 is accepted. Minimum 5 cycles per word.
- Start while not in IDLE is ignored.
- The word index never exceeds DEPTH-1 on any write; there is no wrap-around.
- Simultaneous Reset and Start: Reset wins; state is IDLE and Error=0.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port Checksum [31:0].
  - On each WRITE, Checksum <= Checksum + MemWriteData, mod 2^32.
  - Cleared to 0 on Reset and on accepted Start. Value is stable from the Done pulse until the next Start.
- Undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset then Start with WordCount=1; bytes 0x20,0x08,0x00,0x05 with ByteValid held high -> one MemWrite with MemWriteAddress=0x00000000, MemWriteData=0x20080005; Done pulses 1 cycle later; Busy low afterwards.
- WordCount=3, words 0x00000003, 0x00000006, 0x00000009 -> MemWrite addresses 0x0, 0x4, 0x8 in order with matching data; exactly 3 write strobes; one Done pulse. With LOADER_CHECKSUM_EN defined, Checksum=0x00000012.
- Stalled stream: WordCount=1, ByteValid toggled 1,0,0,1,1,0,1 with bytes 0xAA,0xBB,0xCC,0xDD on the valid cycles -> MemWriteData=0xAABBCCDD; ByteReady stays high in LOAD; no extra bytes consumed.
- WordCount=0, then WordCount=129 -> Error=1, no MemWrite, no Done. A following Start with WordCount=1 clears Error.
- WordCount=128 with 512 bytes -> last write at MemWriteAddress=0x000001FC; Done pulses; no write beyond 0x1FC.
- Reset asserted after 2 bytes of word 1 in a 2-word load -> all outputs 0 next cycle, state IDLE. A new Start with WordCount=1 and bytes 0x11,0x22,0x33,0x44 writes 0x11223344 at address 0x0.

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-stream to 32-bit instruction-memory writer; assembles big-endian words and writes them
// from address 0 upward. Optional Checksum output enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   WordCount,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic [31:0]       MemWriteAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemWrite,
    output logic              Busy,
    output logic              Done,
    output logic              Error
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       Checksum
`endif
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   word_idx_q;
    logic [ADDR_W:0]   word_idx_inc;
    logic [1:0]        byte_idx_q;
    logic [31:0]       asm_q;
    logic              count_ok;
    logic              byte_acc;

    assign count_ok     = (WordCount != '0) && (WordCount <= (ADDR_W + 1)'(DEPTH));
    assign byte_acc     = (state_q == StLoad) && ByteReady && ByteValid;
    // Index is one bit wider than the address so a full 128-word load compares without wrapping.
    assign word_idx_inc = word_idx_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start && count_ok) state_d = StLoad;
            StLoad:  if (byte_acc && (byte_idx_q == 2'd3)) state_d = StWrite;
            StWrite: state_d = (word_idx_inc == count_q) ? StDone : StLoad;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ByteReady       <= 1'b0;
            MemWrite        <= 1'b0;
            MemWriteAddress <= '0;
            MemWriteData    <= '0;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            Error           <= 1'b0;
            count_q         <= '0;
            word_idx_q      <= '0;
            byte_idx_q      <= '0;
            asm_q           <= '0;
`ifdef LOADER_CHECKSUM_EN
            Checksum        <= '0;
`endif
        end else begin
            ByteReady <= (state_d == StLoad);
            Busy      <= (state_d == StLoad) || (state_d == StWrite);
            MemWrite  <= (state_d == StWrite);
            Done      <= (state_d == StDone);
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        Error      <= !count_ok;
                        count_q    <= WordCount;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        Checksum   <= '0;
`endif
                    end
                end
                StLoad: begin
                    if (byte_acc) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        asm_q      <= {asm_q[23:0], ByteIn};
                        if (byte_idx_q == 2'd3) begin
                            MemWriteAddress <= {{(30 - ADDR_W){1'b0}},
                                                word_idx_q[ADDR_W-1:0], 2'b00};
                            MemWriteData    <= {asm_q[23:0], ByteIn};
                        end
                    end
                end
                StWrite: begin
                    word_idx_q <= word_idx_inc;
                    byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                    Checksum   <= Checksum + MemWriteData;
`endif
                end
                StDone: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued as bytes are driven and
// compared by a monitor as MemWrite strobes appear.
module tb_instruction_loader;

    logic        Clk = 1'b0;
    logic        Reset, Start, ByteValid;
    logic [7:0]  WordCount, ByteIn;
    logic        ByteReady, MemWrite, Busy, Done, Error;
    logic [31:0] MemWriteAddress, MemWriteData;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] Checksum;
`endif

    int checks = 0;
    int failures = 0;
    int writes = 0;
    int done_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];

    instruction_loader dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .WordCount(WordCount), .ByteIn(ByteIn),
        .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWriteAddress(MemWriteAddress),
        .MemWriteData(MemWriteData), .MemWrite(MemWrite), .Busy(Busy), .Done(Done),
        .Error(Error)
`ifdef LOADER_CHECKSUM_EN
        , .Checksum(Checksum)
`endif
    );

    always #5 Clk = ~Clk;

    // Write monitor / scoreboard
    always @(negedge Clk) begin
        if (MemWrite) begin
            logic [63:0] e;
            checks++;
            writes++;
            last_addr = MemWriteAddress;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h expected none",
                         MemWriteAddress, MemWriteData);
            end else begin
                e = exp_q.pop_front();
                if ({MemWriteAddress, MemWriteData} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             MemWriteAddress, MemWriteData, e[63:32], e[31:0]);
                end
            end
        end
        if (Done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ByteIn = b;
        ByteValid = 1'b1;
        forever begin
            @(negedge Clk);
            if (ByteReady) break;
            n++;
            if (n > 50) begin
                failures++;
                $display("FAIL byte_ready_timeout got ByteReady=0 expected 1");
                break;
            end
        end
        @(posedge Clk);
        #1;
        ByteValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(8'(w >> (8 * i)));
    endtask

    task automatic do_start(input logic [7:0] c);
        Start = 1'b1;
        WordCount = c;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done got no Done pulse expected one", name);
        end
        @(negedge Clk);
        checks++;
        if ({Done, Busy} !== 2'b00) begin
            failures++;
            $display("FAIL %s_after_done got Done,Busy=%b expected 00", name, {Done, Busy});
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if ({ByteReady, MemWrite, Busy, Done, Error, MemWriteAddress, MemWriteData} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b wr=%b busy=%b done=%b err=%b a=%h d=%h expected 0",
                     ByteReady, MemWrite, Busy, Done, Error, MemWriteAddress, MemWriteData);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic test_single();
        int w0 = writes, d0 = done_cnt;
        do_start(8'd1);
        exp_q.push_back({32'h0, 32'h20080005});
        send_word(32'h20080005);
        wait_done("single");
        checks++;
        if ((writes - w0) != 1 || (done_cnt - d0) != 1) begin
            failures++;
            $display("FAIL single_counts got writes=%0d dones=%0d expected 1 1",
                     writes - w0, done_cnt - d0);
        end
    endtask

    task automatic test_multi();
        int w0 = writes, d0 = done_cnt;
        do_start(8'd3);
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(4 * i), 32'(3 * (i + 1))});
        for (int i = 0; i < 3; i++) send_word(32'(3 * (i + 1)));
        wait_done("multi");
        checks++;
        if ((writes - w0) != 3 || (done_cnt - d0) != 1) begin
            failures++;
            $display("FAIL multi_counts got writes=%0d dones=%0d expected 3 1",
                     writes - w0, done_cnt - d0);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (Checksum !== 32'h12) begin
            failures++;
            $display("FAIL multi_checksum got %h expected 00000012", Checksum);
        end
`endif
    endtask

    task automatic test_stall();
        logic [6:0]  pat = 7'b1011001;  // bit 0 first: 1,0,0,1,1,0,1
        logic [31:0] bytes = 32'hAABBCCDD;
        int j = 0, w0 = writes;
        bit rdy_ok = 1;
        do_start(8'd1);
        exp_q.push_back({32'h0, 32'hAABBCCDD});
        for (int i = 0; i < 7; i++) begin
            ByteValid = pat[i];
            ByteIn = pat[i] ? 8'(bytes >> (8 * (3 - j))) : 8'h5A;
            @(negedge Clk);
            if (ByteReady !== 1'b1) rdy_ok = 0;
            @(posedge Clk);
            #1;
            if (pat[i]) j++;
        end
        ByteValid = 1'b0;
        checks++;
        if (!rdy_ok) begin
            failures++;
            $display("FAIL stall_ready got ByteReady low in LOAD expected high");
        end
        wait_done("stall");
        checks++;
        if ((writes - w0) != 1) begin
            failures++;
            $display("FAIL stall_writes got %0d expected 1", writes - w0);
        end
    endtask

    task automatic test_error();
        int w0 = writes, d0 = done_cnt;
        logic [7:0] bad[2] = '{8'd0, 8'd129};
        for (int k = 0; k < 2; k++) begin
            do_start(bad[k]);
            @(negedge Clk);
            checks++;
            if ({Error, Busy, ByteReady} !== 3'b100) begin
                failures++;
                $display("FAIL error_flag count=%0d got Error,Busy,Rdy=%b expected 100",
                         bad[k], {Error, Busy, ByteReady});
            end
            repeat (4) @(posedge Clk);
            #1;
        end
        checks++;
        if ((writes - w0) != 0 || (done_cnt - d0) != 0) begin
            failures++;
            $display("FAIL error_activity got writes=%0d dones=%0d expected 0 0",
                     writes - w0, done_cnt - d0);
        end
        do_start(8'd1);
        @(negedge Clk);
        checks++;
        if (Error !== 1'b0) begin
            failures++;
            $display("FAIL error_clear got Error=%b expected 0", Error);
        end
        @(posedge Clk);
        #1;
        exp_q.push_back({32'h0, 32'hCAFEF00D});
        send_word(32'hCAFEF00D);
        wait_done("error_recover");
    endtask

    task automatic test_full();
        int w0 = writes, d0 = done_cnt;
        do_start(8'd128);
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back({32'(4 * i), 32'h1357_0000 ^ 32'(i * 32'h0101_0101)});
            send_word(32'h1357_0000 ^ 32'(i * 32'h0101_0101));
        end
        wait_done("full");
        checks++;
        if ((writes - w0) != 128 || (done_cnt - d0) != 1 || last_addr !== 32'h1FC) begin
            failures++;
            $display("FAIL full_counts got writes=%0d dones=%0d last=%h expected 128 1 000001fc",
                     writes - w0, done_cnt - d0, last_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_start(8'd2);
        exp_q.push_back({32'h0, 32'h01020304});
        send_word(32'h01020304);
        send_byte(8'hEE);
        send_byte(8'hFF);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({ByteReady, MemWrite, Busy, Done, Error, MemWriteAddress, MemWriteData} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got rdy=%b wr=%b busy=%b a=%h d=%h expected 0",
                     ByteReady, MemWrite, Busy, MemWriteAddress, MemWriteData);
        end
        @(posedge Clk);
        #1;
        do_start(8'd1);
        exp_q.push_back({32'h0, 32'h11223344});
        send_word(32'h11223344);
        wait_done("reset_mid");
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        WordCount = '0;
        ByteIn = '0;
        ByteValid = 1'b0;
        @(posedge Clk);
        #1;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_error();
        test_full();
        test_reset_mid();
        repeat (5) @(posedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_writes got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
